maze_view_controller: RTL and testbench

Frame-synchronous viewport and zoom controller for the maze renderer. Collects single-cycle navigation and zoom pulses from debounced buttons, applies them only at the start of vertical sync so a frame is never drawn with a half-updated view, and drives the renderer's `x_coord`, `y_coord`, `tile_width`, `tile_height` and `enable` inputs. Sits between the button/debounce logic and the maze renderer; takes `vsync` from the same `vga_sync` instance.

---
 rtl/maze_view_controller.sv | 184 ++++++++++++++++++
 tb/tb_maze_view_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/maze_view_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// maze_view_controller: frame-synchronous viewport/zoom control for the maze renderer.
// Rev 1.0
// ---------------------------------------------------------------------------
module maze_view_controller #(
  parameter logic [1:0] ZOOM_RESET = 2'd1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       vsync_i,
  input  logic       maze_valid_i,
  input  logic [6:0] maze_width_i,
  input  logic [6:0] maze_height_i,
  input  logic       btn_up_i,
  input  logic       btn_down_i,
  input  logic       btn_left_i,
  input  logic       btn_right_i,
  input  logic       zoom_in_i,
  input  logic       zoom_out_i,
  output logic [6:0] x_coord_o,
  output logic [6:0] y_coord_o,
  output logic [7:0] tile_width_o,
  output logic [7:0] tile_height_o,
  output logic       render_enable_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FRAME = 3'd1,
    ST_APPLY      = 3'd2,
    ST_LIMIT      = 3'd3,
    ST_MOVE       = 3'd4
  } state_t;

  localparam int P_UP    = 5;
  localparam int P_DOWN  = 4;
  localparam int P_LEFT  = 3;
  localparam int P_RIGHT = 2;
  localparam int P_ZIN   = 1;
  localparam int P_ZOUT  = 0;

  localparam logic [7:0] TILE_RESET = 8'd4 << ZOOM_RESET;

  state_t      state_q, state_d;
  logic        vsync_q;
  logic [5:0]  pend_q, pend_d;
  logic [5:0]  clr;
  logic [5:0]  pulses;
  logic [1:0]  z_q, z_d;
  logic [7:0]  tile_q, tile_d;
  logic [6:0]  x_q, x_d, y_q, y_d;
  logic [6:0]  max_x_q, max_x_d, max_y_q, max_y_d;
  logic        render_q, render_d;

  logic        frame_edge;
  logic [7:0]  vis_w, vis_h, mw8, mh8, dx, dy;
  logic [6:0]  lim_x, lim_y;

  assign pulses     = {btn_up_i, btn_down_i, btn_left_i, btn_right_i, zoom_in_i, zoom_out_i};
  assign frame_edge = vsync_i & ~vsync_q;

  // Limits use the zoom level already committed in APPLY.
  assign vis_w = 8'd160 >> z_q;
  assign vis_h = 8'd120 >> z_q;
  assign mw8   = {1'b0, maze_width_i};
  assign mh8   = {1'b0, maze_height_i};
  assign dx    = (mw8 > vis_w) ? (mw8 - vis_w) : 8'd0;
  assign dy    = (mh8 > vis_h) ? (mh8 - vis_h) : 8'd0;
  assign lim_x = 7'(dx);
  assign lim_y = 7'(dy);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    max_x_d = max_x_q;
    max_y_d = max_y_q;
    clr     = 6'b0;

    case (state_q)
      ST_IDLE: begin
        if (maze_valid_i) begin
          x_d     = 7'd0;
          y_d     = 7'd0;
          clr     = 6'b111111;
          state_d = ST_WAIT_FRAME;
        end
      end
      ST_WAIT_FRAME: begin
        if (frame_edge) state_d = ST_APPLY;
      end
      ST_APPLY: begin
        if (pend_q[P_ZIN] && !pend_q[P_ZOUT])
          z_d = (z_q == 2'd3) ? 2'd3 : z_q + 2'd1;
        else if (pend_q[P_ZOUT] && !pend_q[P_ZIN])
          z_d = (z_q == 2'd0) ? 2'd0 : z_q - 2'd1;
        clr[P_ZIN]  = 1'b1;
        clr[P_ZOUT] = 1'b1;
        state_d     = ST_LIMIT;
      end
      ST_LIMIT: begin
        max_x_d = lim_x;
        max_y_d = lim_y;
        state_d = ST_MOVE;
      end
      ST_MOVE: begin
        if (pend_q[P_LEFT] && !pend_q[P_RIGHT])
          x_d = (x_q == 7'd0) ? 7'd0 : x_q - 7'd1;
        else if (pend_q[P_RIGHT] && !pend_q[P_LEFT])
          x_d = (x_q >= max_x_q) ? max_x_q : x_q + 7'd1;
        else if (x_q > max_x_q)
          x_d = max_x_q;

        if (pend_q[P_UP] && !pend_q[P_DOWN])
          y_d = (y_q == 7'd0) ? 7'd0 : y_q - 7'd1;
        else if (pend_q[P_DOWN] && !pend_q[P_UP])
          y_d = (y_q >= max_y_q) ? max_y_q : y_q + 7'd1;
        else if (y_q > max_y_q)
          y_d = max_y_q;

        clr[P_UP]    = 1'b1;
        clr[P_DOWN]  = 1'b1;
        clr[P_LEFT]  = 1'b1;
        clr[P_RIGHT] = 1'b1;
        state_d      = ST_WAIT_FRAME;
      end
      default: state_d = ST_IDLE;
    endcase

    // Losing the maze abandons any in-flight update but keeps the zoom level.
    if (state_q != ST_IDLE && !maze_valid_i) begin
      state_d = ST_IDLE;
      x_d     = 7'd0;
      y_d     = 7'd0;
      z_d     = z_q;
      max_x_d = max_x_q;
      max_y_d = max_y_q;
      clr     = 6'b0;
    end

    pend_d   = (pend_q & ~clr) | pulses;
    tile_d   = 8'd4 << z_d;
    render_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      vsync_q  <= 1'b0;
      pend_q   <= 6'b0;
      z_q      <= ZOOM_RESET;
      tile_q   <= TILE_RESET;
      x_q      <= 7'd0;
      y_q      <= 7'd0;
      max_x_q  <= 7'd0;
      max_y_q  <= 7'd0;
      render_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vsync_q  <= vsync_i;
      pend_q   <= pend_d;
      z_q      <= z_d;
      tile_q   <= tile_d;
      x_q      <= x_d;
      y_q      <= y_d;
      max_x_q  <= max_x_d;
      max_y_q  <= max_y_d;
      render_q <= render_d;
    end
  end

  assign x_coord_o       = x_q;
  assign y_coord_o       = y_q;
  assign tile_width_o    = tile_q;
  assign tile_height_o   = tile_q;
  assign render_enable_o = render_q;
  assign busy_o          = (state_q == ST_APPLY) || (state_q == ST_LIMIT) || (state_q == ST_MOVE);

endmodule
`default_nettype wire

// File: tb/tb_maze_view_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_maze_view_controller: directed frames with a scoreboard checked at each update end.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_maze_view_controller;

  localparam logic [5:0] UP    = 6'b100000;
  localparam logic [5:0] DOWN  = 6'b010000;
  localparam logic [5:0] LEFT  = 6'b001000;
  localparam logic [5:0] RIGHT = 6'b000100;
  localparam logic [5:0] ZIN   = 6'b000010;
  localparam logic [5:0] ZOUT  = 6'b000001;
  localparam logic [5:0] NONE  = 6'b000000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b0;
  logic       maze_valid = 1'b0;
  logic [6:0] maze_w = 7'd0;
  logic [6:0] maze_h = 7'd0;
  logic       b_up = 1'b0, b_down = 1'b0, b_left = 1'b0, b_right = 1'b0;
  logic       z_in = 1'b0, z_out = 1'b0;
  logic [6:0] x_coord, y_coord;
  logic [7:0] tile_w, tile_h;
  logic       render_en, busy;

  int tests = 0;
  int fails = 0;
  int busy_cnt = 0;
  logic busy_prev = 1'b0;
  logic [21:0] exp_q[$];

  maze_view_controller #(.ZOOM_RESET(2'd1)) dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .vsync_i        (vsync),
    .maze_valid_i   (maze_valid),
    .maze_width_i   (maze_w),
    .maze_height_i  (maze_h),
    .btn_up_i       (b_up),
    .btn_down_i     (b_down),
    .btn_left_i     (b_left),
    .btn_right_i    (b_right),
    .zoom_in_i      (z_in),
    .zoom_out_i     (z_out),
    .x_coord_o      (x_coord),
    .y_coord_o      (y_coord),
    .tile_width_o   (tile_w),
    .tile_height_o  (tile_h),
    .render_enable_o(render_en),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: an update sequence completes when busy falls with rendering still on.
  always @(negedge clk) begin
    logic [21:0] e;
    if (busy_prev && !busy && render_en) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL frame_unexpected: got x=%0d y=%0d tile=%0d, required no update", x_coord, y_coord, tile_w);
      end else begin
        e = exp_q.pop_front();
        if (x_coord !== e[21:15] || y_coord !== e[14:8] || tile_w !== e[7:0] || tile_h !== e[7:0]) begin
          fails++;
          $display("FAIL frame_result: got x=%0d y=%0d tw=%0d th=%0d, required x=%0d y=%0d tile=%0d",
                   x_coord, y_coord, tile_w, tile_h, e[21:15], e[14:8], e[7:0]);
        end
      end
    end
    if (busy) busy_cnt++;
    busy_prev = busy;
  end

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic drive_pulses(input logic [5:0] p);
    {b_up, b_down, b_left, b_right, z_in, z_out} = p;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL frame_timeout: got %0d pending results, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic frame(input logic [5:0] p, input logic [6:0] ex, input logic [6:0] ey, input logic [7:0] et);
    exp_q.push_back({ex, ey, et});
    @(posedge clk); #1;
    drive_pulses(p);
    @(posedge clk); #1;
    drive_pulses(NONE);
    vsync = 1'b1;
    repeat (8) @(posedge clk);
    #1 vsync = 1'b0;
    wait_done();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_x"}, int'(x_coord), 0);
    chk({tag, "_y"}, int'(y_coord), 0);
    chk({tag, "_tile"}, int'(tile_w), 8);
    chk({tag, "_render"}, int'(render_en), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");

    // 100x100 maze, default zoom 1: enable one cycle after valid, idle frames.
    @(posedge clk); #1;
    maze_w = 7'd100; maze_h = 7'd100; maze_valid = 1'b1;
    @(negedge clk);
    chk("render_same_cycle", int'(render_en), 0);
    @(negedge clk);
    chk("render_next_cycle", int'(render_en), 1);
    busy_cnt = 0;
    for (int i = 0; i < 3; i++) frame(NONE, 7'd0, 7'd0, 8'd8);
    chk("busy_cycles_3_frames", busy_cnt, 9);

    // Right moves saturate at max_x=20, opposing moves cancel.
    for (int i = 1; i <= 25; i++) frame(RIGHT, 7'((i > 20) ? 20 : i), 7'd0, 8'd8);
    frame(LEFT | RIGHT, 7'd20, 7'd0, 8'd8);

    // Zoom to 3 and walk to x=70, then zoom out clamps x to the new limit of 60.
    frame(ZIN, 7'd20, 7'd0, 8'd16);
    frame(ZIN, 7'd20, 7'd0, 8'd32);
    for (int i = 21; i <= 70; i++) frame(RIGHT, 7'(i), 7'd0, 8'd32);
    frame(ZOUT, 7'd60, 7'd0, 8'd16);

    // Switch to a 30x20 maze; at zoom 0 both limits are zero.
    @(posedge clk); #1 maze_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("invalid_render", int'(render_en), 0);
    chk("invalid_x", int'(x_coord), 0);
    maze_w = 7'd30; maze_h = 7'd20;
    @(posedge clk); #1 maze_valid = 1'b1;
    frame(ZOUT, 7'd0, 7'd0, 8'd8);
    frame(ZOUT, 7'd0, 7'd0, 8'd4);
    for (int i = 0; i < 4; i++) frame(RIGHT | DOWN, 7'd0, 7'd0, 8'd4);
    frame(ZIN, 7'd0, 7'd0, 8'd8);
    frame(ZIN, 7'd0, 7'd0, 8'd16);
    frame(ZIN, 7'd0, 7'd0, 8'd32);
    frame(ZIN, 7'd0, 7'd0, 8'd32);

    // Up pulse landing in the MOVE cycle is deferred to the next frame (zoom 3: max_y=5).
    frame(DOWN, 7'd0, 7'd1, 8'd32);
    exp_q.push_back({7'd0, 7'd1, 8'd32});
    @(posedge clk); #1 vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("move_cycle_busy", int'(busy), 1);
    b_up = 1'b1;
    @(posedge clk); #1 b_up = 1'b0;
    repeat (6) @(posedge clk);
    #1 vsync = 1'b0;
    wait_done();
    frame(NONE, 7'd0, 7'd0, 8'd32);

    // maze_valid dropped during APPLY.
    frame(RIGHT | DOWN, 7'd1, 7'd1, 8'd32);
    @(posedge clk); #1 vsync = 1'b1;
    @(posedge clk); #1;
    chk("apply_busy", int'(busy), 1);
    maze_valid = 1'b0;
    @(posedge clk); #1;
    chk("drop_render", int'(render_en), 0);
    chk("drop_x", int'(x_coord), 0);
    chk("drop_y", int'(y_coord), 0);
    chk("drop_busy", int'(busy), 0);
    chk("drop_tile_kept", int'(tile_w), 32);
    vsync = 1'b0;
    @(posedge clk); #1 maze_valid = 1'b1;
    frame(RIGHT, 7'd1, 7'd0, 8'd32);

    // Async reset during MOVE.
    @(posedge clk); #1 vsync = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_busy", int'(busy), 1);
    chk("pre_reset_x", int'(x_coord), 1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    vsync = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
